// File: rtl/ysyx_22050243_lsu_pkg.sv
// ysyx_22050243 LSU shared definitions: funct3 codes, FSM states
// and the access-size decode used by the LSU top and align logic.
package ysyx_22050243_lsu_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LD  = 3'b011;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] LWU = 3'b110;

    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;
    localparam logic [2:0] SD  = 3'b011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        RESP = 2'd3
    } lsu_state_e;

    // Access size in bytes from funct3[1:0]: 1, 2, 4 or 8.
    function automatic logic [3:0] size_bytes(input logic [1:0] sz);
        return 4'd1 << sz;
    endfunction

endpackage

// File: rtl/ysyx_22050243_lsu_align.sv
// ysyx_22050243 LSU lane logic (combinational): store shift and byte
// mask, load extract with sign/zero extension, misalign/funct3 check.
// Ports: we, funct3, off (addr[2:0]), wdata, rdata in;
//        w_data, w_mask, r_data, err out.
module ysyx_22050243_lsu_align
    import ysyx_22050243_lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int MASK_WIDTH = 8
) (
    input  logic                  we,
    input  logic [2:0]            funct3,
    input  logic [2:0]            off,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic [DATA_WIDTH-1:0] w_data,
    output logic [MASK_WIDTH-1:0] w_mask,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic                  err
);

    logic [5:0]            sh_amt;
    logic [DATA_WIDTH-1:0] r_sh;
    logic [MASK_WIDTH-1:0] base_mask;
    logic                  misalign;
    logic                  bad_f3;
    logic                  sext;

    always_comb begin
        sh_amt    = {off, 3'b000};
        r_sh      = rdata >> sh_amt;
        sext      = ~funct3[2];
        base_mask = '0;
        misalign  = 1'b0;
        r_data    = '0;
        unique case (funct3[1:0])
            2'd0: begin
                base_mask = MASK_WIDTH'(8'h01);
                misalign  = 1'b0;
                r_data    = {{(DATA_WIDTH-8){sext & r_sh[7]}}, r_sh[7:0]};
            end
            2'd1: begin
                base_mask = MASK_WIDTH'(8'h03);
                misalign  = off[0];
                r_data    = {{(DATA_WIDTH-16){sext & r_sh[15]}}, r_sh[15:0]};
            end
            2'd2: begin
                base_mask = MASK_WIDTH'(8'h0F);
                misalign  = |off[1:0];
                r_data    = {{(DATA_WIDTH-32){sext & r_sh[31]}}, r_sh[31:0]};
            end
            2'd3: begin
                base_mask = MASK_WIDTH'(8'hFF);
                misalign  = |off;
                r_data    = r_sh;
            end
        endcase
        // Stores only support SB..SD; loads reject only 3'b111.
        bad_f3 = we ? funct3[2] : (funct3 == 3'b111);
        err    = misalign | bad_f3;
        w_data = wdata << sh_amt;
        w_mask = base_mask << off;
    end

endmodule

// File: rtl/ysyx_22050243_lsu.sv
// ysyx_22050243 MEM-stage load/store unit: one request per instruction,
// registered bus (w_en/ready, r_en/valid) and one-cycle response.
// Ports: req_* from EX/MEM, resp_* to MEM/WB, data_* core data port.
// Optional bus watchdog: define LSU_TIMEOUT_EN (TIMEOUT_CYCLES limit).
module ysyx_22050243_lsu
    import ysyx_22050243_lsu_pkg::*;
#(
    parameter int ADDR_WIDTH     = 64,
    parameter int DATA_WIDTH     = 64,
    parameter int MASK_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  data_w_en_o,
    output logic [ADDR_WIDTH-1:0] data_w_addr_o,
    output logic [DATA_WIDTH-1:0] data_w_o,
    output logic [MASK_WIDTH-1:0] data_w_mask_o,
    input  logic                  i_data_w_ready,
    output logic                  data_r_en_o,
    output logic [ADDR_WIDTH-1:0] data_r_addr_o,
    input  logic                  i_data_r_valid,
    input  logic [DATA_WIDTH-1:0] i_data_r
);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    lsu_state_e            state;
    lsu_state_e            state_nx;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [MASK_WIDTH-1:0] mask_q;
    logic [2:0]            f3_q;
    logic [2:0]            off_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic                  idle;
    logic                  accept;
    logic                  hs;
    logic                  to_hit;

    logic [2:0]            al_f3;
    logic [2:0]            al_off;
    logic [DATA_WIDTH-1:0] al_wdata;
    logic [MASK_WIDTH-1:0] al_mask;
    logic [DATA_WIDTH-1:0] al_rdata;
    logic                  al_err;

    assign idle   = (state == IDLE);
    assign accept = idle & req_valid;
    assign hs     = ((state == WR) & i_data_w_ready)
                  | ((state == RD) & i_data_r_valid);

    // One align instance: in IDLE it checks/shifts the incoming request,
    // afterwards it extracts load data using the latched size/offset.
    assign al_f3  = idle ? req_funct3    : f3_q;
    assign al_off = idle ? req_addr[2:0] : off_q;

    ysyx_22050243_lsu_align #(
        .DATA_WIDTH (DATA_WIDTH),
        .MASK_WIDTH (MASK_WIDTH)
    ) u_align (
        .we     (req_we),
        .funct3 (al_f3),
        .off    (al_off),
        .wdata  (req_wdata),
        .rdata  (i_data_r),
        .w_data (al_wdata),
        .w_mask (al_mask),
        .r_data (al_rdata),
        .err    (al_err)
    );

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES) > 8)
                         ? $clog2(TIMEOUT_CYCLES) : 8;

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || idle) begin
            cnt <= '0;
        end else if (state == WR || state == RD) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign to_hit = (state == WR || state == RD)
                  && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    if (al_err) begin
                        state_nx = RESP;
                    end else begin
                        state_nx = req_we ? WR : RD;
                    end
                end
            end
            WR, RD: begin
                if (hs || to_hit) begin
                    state_nx = RESP;
                end
            end
            RESP: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            mask_q  <= '0;
            f3_q    <= '0;
            off_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                addr_q  <= {req_addr[ADDR_WIDTH-1:3], 3'b000};
                wdata_q <= al_wdata;
                mask_q  <= al_mask;
                f3_q    <= req_funct3;
                off_q   <= req_addr[2:0];
                err_q   <= al_err;
                rdata_q <= '0;
            end
            if (state == RD && i_data_r_valid) begin
                rdata_q <= al_rdata;
            end
            if (to_hit && !hs) begin
                err_q   <= 1'b1;
                rdata_q <= '0;
            end
        end
    end

    always_comb begin
        req_ready     = idle;
        data_w_en_o   = (state == WR);
        data_w_addr_o = (state == WR) ? addr_q  : '0;
        data_w_o      = (state == WR) ? wdata_q : '0;
        data_w_mask_o = (state == WR) ? mask_q  : '0;
        data_r_en_o   = (state == RD);
        data_r_addr_o = (state == RD) ? addr_q  : '0;
        resp_valid    = (state == RESP);
        resp_err      = (state == RESP) & err_q;
        resp_rdata    = (state == RESP) ? rdata_q : '0;
    end

endmodule

// File: doc/ysyx_22050243_lsu.md
Name: ysyx_22050243_lsu

Overview:
- Load/store unit for the MEM stage of the 5-stage ysyx_22050243 RISC-V core.
- Consumes one memory request per instruction from EX/MEM and drives the core data port (write channel: w_en/ready; read channel: r_en/valid).
- Byte-aligns store data, builds the 8-bit write mask, extracts and sign/zero-extends load data, and returns a single-cycle response to MEM/WB.
- Stalls the pipeline through req_ready until the bus completes.

Parameters:
- ADDR_WIDTH, 64, data-bus address width.
- DATA_WIDTH, 64, data-bus data width; fixed at 64 (RV64).
- MASK_WIDTH, 8, byte-mask width; equals DATA_WIDTH/8.
- TIMEOUT_CYCLES, 256, bus watchdog limit; used only with LSU_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- req_valid  in  1  MEM-stage request present
- req_ready  out  1  LSU idle; request accepted when valid&&ready
- req_we  in  1  1=store, 0=load
- req_funct3  in  3  RV funct3 (size/sign)
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  DATA_WIDTH  store data, LSB-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  DATA_WIDTH  extended load data; 0 for stores
- resp_err  out  1  misaligned, invalid funct3, or timeout
- data_w_en_o  out  1  write request
- data_w_addr_o  out  ADDR_WIDTH  8-byte-aligned write address
- data_w_o  out  DATA_WIDTH  lane-shifted write data
- data_w_mask_o  out  MASK_WIDTH  byte-enable mask
- i_data_w_ready  in  1  write accepted
- data_r_en_o  out  1  read request
- data_r_addr_o  out  ADDR_WIDTH  8-byte-aligned read address
- i_data_r_valid  in  1  read data valid
- i_data_r  in  DATA_WIDTH  read data, full 64-bit word

Behaviour:
- Reset (rst=1 at posedge): state returns to IDLE. All bus and response outputs are 0; req_ready=1. This applies mid-transaction: an in-flight request is dropped and no response is produced.
- All outputs are registered; there are no combinational paths from bus inputs to outputs.
- Size encoding: funct3[1:0] gives 1, 2, 4 or 8 bytes. For loads, funct3[2]=1 means zero-extend. Valid loads: 000-110. Valid stores: 000-011.
- Errors: 111 on a load, or 1xx on a store, sets resp_err.
- Misalignment: addr[2:0] not a multiple of the access size sets resp_err. No bus transaction is issued.
- Store lanes: off=addr[2:0]. data_w_o = wdata << (8*off). data_w_mask_o = ((1<<size)-1) << off.
- Load lanes: shift i_data_r right by 8*off, then truncate to size and sign- or zero-extend.
- Bus address: req_addr with bits [2:0] cleared.
- FSM states:
  - IDLE: req_ready=1. On a good request, latch it and go to WR (store) or RD (load). On a bad request, go to RESP with err=1.
  - WR: data_w_en_o=1 with addr, data and mask held stable. On i_data_w_ready, go to RESP.
  - RD: data_r_en_o=1 with addr held stable. On i_data_r_valid, capture the extended i_data_r and go to RESP.
  - RESP: resp_valid=1 for exactly one cycle, then go to IDLE. req_ready=0 in this state.
- Latency: accept at cycle 0 and enable at cycle 1. For ready/valid seen at cycle N, resp_valid is at cycle N+1. With zero-wait memory, a request completes in 3 cycles. Back-to-back throughput is one request per 3 cycles.
- Enables drop in the cycle after the handshake. A ready or valid that arrives while the LSU is in IDLE or RESP is ignored.
- A request with req_valid=0 produces no state change.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined:
  - An 8-bit+ counter clears on entry to WR/RD and increments each waiting cycle.
  - When the count reaches TIMEOUT_CYCLES-1 without a handshake, the enable drops and the FSM goes to RESP with resp_err=1 and resp_rdata=0.
- Undefined:
  - No counter is built; WR/RD wait indefinitely.
  - resp_err reports only misalignment or an invalid funct3.

Decomposition:
- Package ysyx_22050243_lsu_pkg contains:
  - funct3 constants (LB/LH/LW/LD/LBU/LHU/LWU, SB/SH/SW/SD)
  - FSM state enum (IDLE/WR/RD/RESP)
  - a size-decode function
- Sub-module ysyx_22050243_lsu_align: purely combinational. Computes store shift/mask, load extract/extend and the misalign check. The FSM top instantiates it once.

Test Plan:
- SD at addr 0x80000010, wdata 0x1122334455667788, ready at the 2nd enable cycle:
  - data_w_addr_o=0x80000010, mask=0xFF, data unchanged.
  - resp_valid one cycle later with err=0 and rdata=0.
- SB at 0x80000003, wdata 0xAB: data_w_o=0x00000000AB000000, mask=0x08.
- Sign/zero extension with i_data_r=0x00000000_80FF0000 (valid same cycle):
  - LH at 0x80000002: rdata=0xFFFFFFFFFFFF80FF.
  - LHU at the same address: rdata=0x00000000000080FF.
- LW at 0x80000006 (misaligned): no data_r_en_o pulse; resp_valid next cycle with resp_err=1.
- Reset mid-transaction: assert rst during RD with valid withheld.
  - Next cycle: data_r_en_o=0, req_ready=1, no resp_valid.
  - A following LD completes normally.
- With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=4, a store with ready tied to 0:
  - resp_valid with resp_err=1 exactly 4 enable cycles after the enable rises.
